// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared op encodings and default latencies for the multiply/divide unit
package md_unit_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
endpackage

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned 32-bit quotient and remainder with MIPS divide-by-zero result
module md_divider (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] q,
  output logic [31:0] r
);
  logic        na, nb, bz;
  logic [31:0] ua, ub, dv, uq, ur;
  assign na = sgn & a[31];
  assign nb = sgn & b[31];
  assign bz = b == '0;
  assign ua = na ? -a : a;
  assign ub = nb ? -b : b;
  assign dv = bz ? 32'd1 : ub;
  assign uq = ua / dv;
  assign ur = ua % dv;
  assign q  = bz ? '1 : ((na ^ nb) ? -uq : uq);
  assign r  = bz ? a : (na ? -ur : ur);
endmodule

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with a fixed-latency busy window and deferred commit
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;
  logic          state;
  logic [CW-1:0] cnt;
  logic [31:0]   phi, plo, q, r;
  logic [63:0]   prod;
  logic          isdiv, sgn, md;
  assign isdiv = op == OP_DIV || op == OP_DIVU;
  assign sgn   = op == OP_MULT || op == OP_DIV;
  assign md    = isdiv || op == OP_MULT || op == OP_MULTU;
  assign prod  = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
  assign busy  = state == S_RUN;
  md_divider u_div (
    .a  (a),
    .b  (b),
    .sgn(sgn),
    .q  (q),
    .r  (r)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      phi   <= '0;
      plo   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi    <= phi;
        lo    <= plo;
        state <= S_IDLE;
      end
    end else if (start) begin
      if (op == OP_MTHI) hi <= a;
      if (op == OP_MTLO) lo <= a;
      if (md) begin
        {phi, plo} <= isdiv ? {r, q} : prod;
        cnt        <= isdiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state      <= S_RUN;
      end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit against an arithmetic HI/LO model plus literal expectations
module tb_md_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int          n_cmp = 0, n_fail = 0;
  logic        cmp_en = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_rem = 0;

  md_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] f_mult(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    p = sx * sy;
    return 64'(p);
  endfunction

  function automatic logic [63:0] f_div(input logic s, input logic [31:0] x, input logic [31:0] y);
    int qi, ri;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (!s) return {x % y, x / y};
    qi = $signed(x) / $signed(y);
    ri = $signed(x) % $signed(y);
    return {32'(ri), 32'(qi)};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_rem  <= 0;
      m_pend <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) {m_hi, m_lo} <= m_pend;
    end else if (start) begin
      if (op == 3'b100) m_hi <= a;
      if (op == 3'b101) m_lo <= a;
      if (op == 3'b000 || op == 3'b001) begin
        m_pend <= f_mult(op == 3'b000, a, b);
        m_rem  <= 5;
      end
      if (op == 3'b010 || op == 3'b011) begin
        m_pend <= f_div(op == 3'b010, a, b);
        m_rem  <= 10;
      end
    end

  always @(negedge clk)
    if (cmp_en) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_rem != 0});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    op = 3'b111;
  endtask

  task automatic busy_len(input string name, input int exp);
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(exp));
  endtask

  task automatic expect_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    expect_hl("rst", 32'd0, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    busy_len("mult_busy_len", 5);
    expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(3'b011, 32'd100, 32'd7);
    busy_len("divu_busy_len", 10);
    expect_hl("divu", 32'd2, 32'd14);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    busy_len("div_neg_len", 10);
    expect_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b010, 32'd5, 32'd0);
    busy_len("div0_len", 10);
    expect_hl("div0", 32'd5, 32'hFFFF_FFFF);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("divovf_len", 10);
    expect_hl("divovf", 32'd0, 32'h8000_0000);
    issue(3'b100, 32'h1234, 32'd0);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    expect_hl("mthi", 32'h1234, 32'h8000_0000);
    issue(3'b000, 32'd7, 32'd6);
    @(negedge clk);
    issue(3'b101, 32'hDEAD_BEEF, 32'd0);
    busy_len("mtlo_ign_len", 3);
    expect_hl("mtlo_ign", 32'd0, 32'd42);
    issue(3'b110, 32'h5555_5555, 32'd9);
    chk("nop_busy", {31'b0, busy}, 32'd0);
    expect_hl("nop", 32'd0, 32'd42);
    issue(3'b011, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    expect_hl("abort", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle", {31'b0, busy}, 32'd0);
    expect_hl("abort_after", 32'd0, 32'd0);
    issue(3'b011, 32'd50, 32'd5);
    busy_len("b2b_div_len", 10);
    issue(3'b001, 32'hFFFF_FFFF, 32'd2);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    expect_hl("b2b_div", 32'd0, 32'd10);
    busy_len("b2b_mult_len", 5);
    expect_hl("b2b_multu", 32'd1, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
